// File: rtl/bin_display_driver_if.sv
// Bus between the Gray-to-binary stage, the display driver and the display pins.
`timescale 1ns/1ps

interface bin_display_driver_if;
  logic [3:0] bin_in;
  logic       bin_valid;
  logic [3:0] bin_held;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output bin_in,
    output bin_valid,
    input  bin_held,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  bin_in,
    input  bin_valid,
    output bin_held,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/bin_display_driver.sv
// Captures a 4-bit binary value and shows it as 00-15 on a two-digit,
// time-multiplexed, active-low 7-segment display. The tens digit is blanked
// when zero. The units decimal point marks a recent value change.
`timescale 1ns/1ps

module bin_display_driver #(
  parameter int REFRESH_CYCLES  = 100000,
  parameter int NEW_FLAG_CYCLES = 50000000
) (
  input  logic                 reloj,
  input  logic                 reset_n,
  bin_display_driver_if.slave  bus
);

  localparam int SLOT_W = $clog2(REFRESH_CYCLES);
  localparam int FLAG_W = $clog2(NEW_FLAG_CYCLES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_CYCLES - 1);
  localparam logic [FLAG_W-1:0] FLAG_LOAD = FLAG_W'(NEW_FLAG_CYCLES);

  typedef enum logic {
    DIG_U = 1'b0,
    DIG_T = 1'b1
  } scan_state_t;

  logic [3:0]        bin_held_q, bin_held_d;
  logic [FLAG_W-1:0] flag_cnt_q, flag_cnt_d;
  scan_state_t       state_q, state_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              tens;
  logic [3:0]        units;

  // Active-low gfedcba pattern for one decimal digit; anything else is dark.
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  // Split the held value into a tens bit and a 0-9 units digit.
  always_comb begin
    tens  = (bin_held_q >= 4'd10);
    units = tens ? (bin_held_q - 4'd10) : bin_held_q;
  end

  // Capture the input and restart the change flag only when the value differs;
  // a fresh load takes priority over the countdown.
  always_comb begin
    bin_held_d = bin_held_q;
    flag_cnt_d = flag_cnt_q;
    if (flag_cnt_q != '0) begin
      flag_cnt_d = flag_cnt_q - FLAG_W'(1);
    end
    if (bus.bin_valid) begin
      bin_held_d = bus.bin_in;
      if (bus.bin_in != bin_held_q) begin
        flag_cnt_d = FLAG_LOAD;
      end
    end
  end

  // Free-running scan: each digit slot lasts REFRESH_CYCLES, then the other digit takes over.
  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q + SLOT_W'(1);
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      state_d    = (state_q == DIG_U) ? DIG_T : DIG_U;
    end
  end

  // Next display pins from the current slot, held value and flag.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (state_q == DIG_U) begin
      an_d  = 4'b1110;
      seg_d = enc(units);
      dp_d  = (flag_cnt_q == '0);
    end else if (tens) begin
      an_d  = 4'b1101;
      seg_d = enc(4'd1);
    end
  end

  // All state and registered display outputs; reset blanks the display at once.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      bin_held_q <= 4'd0;
      flag_cnt_q <= '0;
      state_q    <= DIG_U;
      slot_cnt_q <= '0;
      an_q       <= 4'b1111;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
    end else begin
      bin_held_q <= bin_held_d;
      flag_cnt_q <= flag_cnt_d;
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.bin_held = bin_held_q;
  assign bus.an       = an_q;
  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;

endmodule

// File: tb/tb_bin_display_driver.sv
// Scoreboard bench for bin_display_driver with short refresh and flag times.
`timescale 1ns/1ps

module tb_bin_display_driver;

  localparam int R = 4;
  localparam int N = 10;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] held;
    string      tag;
  } exp_t;

  logic reloj;
  logic reset_n;
  bin_display_driver_if bus();

  bin_display_driver #(
    .REFRESH_CYCLES (R),
    .NEW_FLAG_CYCLES(N)
  ) dut (
    .reloj  (reloj),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [3:0] curHeld = 4'd0;
  int         flagUntil = 0;
  string      curTag = "reset";

  logic [6:0] encTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  // Clock
  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // Rising edges since the last reset release; edge 1 is the first update.
  always @(posedge reloj or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic checkOutput(input exp_t e);
    tests++;
    if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp || bus.bin_held !== e.held) begin
      fails++;
      $display("[TB] FAIL %s edge=%0d an=%b exp %b seg=%b exp %b dp=%b exp %b held=%h exp %h",
               e.tag, e.cyc, bus.an, e.an, bus.seg, e.seg, bus.dp, e.dp, bus.bin_held, e.held);
    end
  endtask

  // Monitor: the display is presented every cycle; compare all due entries.
  always @(negedge reloj) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checkOutput(sb.pop_front());
    end
  end

  // Drive one cycle of input and queue the outputs expected after the next edge.
  task automatic applyStimulus(input logic valid, input logic [3:0] value);
    exp_t       e;
    int         k;
    logic [3:0] u;
    k = cyc + 1;
    bus.bin_valid = valid;
    bus.bin_in    = value;
    e.cyc = k;
    e.tag = curTag;
    e.dp  = 1'b1;
    if (((k - 1) / R) % 2 == 0) begin
      u     = (curHeld >= 4'd10) ? curHeld - 4'd10 : curHeld;
      e.an  = 4'b1110;
      e.seg = encTab[u];
      e.dp  = (k <= flagUntil) ? 1'b0 : 1'b1;
    end else if (curHeld >= 4'd10) begin
      e.an  = 4'b1101;
      e.seg = 7'b1111001;
    end else begin
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
    end
    if (valid) begin
      if (value != curHeld) flagUntil = k + N;
      curHeld = value;
    end
    e.held = curHeld;
    sb.push_back(e);
    @(posedge reloj);
    @(negedge reloj);
    #1;
  endtask

  task automatic expectReset();
    exp_t e;
    e.cyc  = 0;
    e.an   = 4'b1111;
    e.seg  = 7'b1111111;
    e.dp   = 1'b1;
    e.held = 4'd0;
    e.tag  = curTag;
    sb.push_back(e);
    @(negedge reloj);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, bus.bin_in);
  endtask

  task automatic release_reset();
    reset_n   = 1'b1;
    curHeld   = 4'd0;
    flagUntil = 0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d entries pending", sb.size());
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence
  initial begin
    reset_n       = 1'b0;
    bus.bin_in    = 4'd0;
    bus.bin_valid = 1'b0;
    @(negedge reloj);
    #1;
    curTag = "reset_hold";
    repeat (3) expectReset();

    release_reset();
    curTag = "idle_zero";
    idle(10);

    curTag = "single_7";
    applyStimulus(1'b1, 4'd7);
    idle(16);

    curTag = "two_digit_13";
    applyStimulus(1'b1, 4'd13);
    idle(16);

    curTag = "unchanged_13";
    applyStimulus(1'b1, 4'd13);
    idle(8);

    curTag = "restart_14_15";
    applyStimulus(1'b1, 4'd14);
    idle(4);
    applyStimulus(1'b1, 4'd15);
    idle(14);

    curTag = "sweep";
    for (int v = 0; v < 16; v++) begin
      for (int j = 0; j < 2 * R; j++) applyStimulus(1'b1, 4'(v));
    end
    bus.bin_valid = 1'b0;

    curTag = "pre_reset_12";
    applyStimulus(1'b1, 4'd12);
    for (int i = 0; i < 2 * R && ((cyc / R) % 2) != 1; i++) applyStimulus(1'b0, 4'd12);
    @(posedge reloj);
    #1;
    reset_n = 1'b0;
    #1;
    curTag = "mid_reset";
    repeat (3) expectReset();

    release_reset();
    curTag = "after_reset";
    idle(10);

    @(negedge reloj);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("[TB] FAIL leftover %s edge=%0d never compared (now %0d)", e.tag, e.cyc, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin_display_driver.md
# bin_display_driver

Downstream stage of the Gray-to-binary conversion submodule. It captures the 4-bit binary value that stage produces and shows it in decimal (00–15) on a time-multiplexed, active-low 7-segment display. The tens digit is blanked when it is zero. The decimal point of the units digit is lit for a fixed time after the displayed value changes.

## Interface
- REFRESH_CYCLES, 100000, clock cycles each digit stays active per scan slot (≥2)
- NEW_FLAG_CYCLES, 50000000, clock cycles the decimal point stays lit after a value change (≥1)
- reloj  in  1  system clock, rising-edge active
- reset_n  in  1  reset, asynchronous assert, active-low
- bin_in  in  4  binary value from the Gray-to-binary stage
- bin_valid  in  1  capture strobe; may be held high continuously
- bin_held  out  4  currently captured value
- an  out  4  digit anodes, active-low; an[0] = units, an[1] = tens, an[3:2] always 1
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active-low

## Operation
- Capture register:
  - On each rising edge with bin_valid = 1, bin_held <= bin_in.
  - If bin_in != bin_held, the flag timer loads NEW_FLAG_CYCLES.
  - An equal value leaves the timer untouched.
- Flag timer:
  - Decrements by 1 each cycle while nonzero and saturates at 0.
  - When a load and a decrement fall in the same cycle, the load wins.
- BCD split, combinational from bin_held:
  - tens = 1 if bin_held ≥ 10, else 0.
  - units = bin_held − 10·tens, range 0–9.
- Scan state machine, 2 states:
  - DIG_U: units slot. DIG_T: tens slot.
  - Slot counter runs 0..REFRESH_CYCLES−1.
  - On wrap: counter goes to 0 and the state toggles DIG_U ↔ DIG_T.
  - No other transitions.
- Registered outputs, recomputed every cycle from the state and counter values present before that edge:
  - DIG_U: an = 1110, seg = enc(units), dp = 0 if timer ≠ 0 else 1.
  - DIG_T with tens = 1: an = 1101, seg = enc(1), dp = 1.
  - DIG_T with tens = 0: an = 1111 (blanked), seg = 1111111, dp = 1.
- Segment encoding enc(d), active-low gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Values outside 0–15 cannot occur, since the input is 4 bits; no saturation logic is needed.
- Reset (reset_n = 0, any time including mid-scan or mid-flag), effective immediately:
  - bin_held = 0, flag timer = 0.
  - State = DIG_U, slot counter = 0.
  - an = 1111, seg = 1111111, dp = 1.

## Timing
- First output update happens on the first rising edge after reset_n deasserts: an = 1110, seg = 1000000 (shows "0").
- Capture latency:
  - bin_valid sampled at edge k updates bin_held at edge k.
  - seg, dp and an reflect the new value from edge k+1 whenever the relevant slot is active.
- Each slot lasts exactly REFRESH_CYCLES cycles; a full scan period is 2·REFRESH_CYCLES.
- After a value change at edge k, dp is low during units slots for NEW_FLAG_CYCLES cycles.
  - A change during that window restarts the full interval.
- Capture never resets the scan counter or state; the scan runs freely.
- Back-to-back bin_valid pulses on consecutive cycles are all captured. The last one determines bin_held.

## Test plan
- Reset and idle (REFRESH_CYCLES=4, NEW_FLAG_CYCLES=10):
  - Hold reset_n=0 → an=1111, seg=1111111, dp=1.
  - Release → an alternates 1110 for 4 cycles, then 1111 for 4 cycles; seg=1000000 in the units slot; dp=1 throughout.
- Single value: bin_in=0111, bin_valid pulse → bin_held=0111; units slot seg=1111000; tens slot an=1111; dp=0 for 10 cycles, then 1.
- Two-digit value: bin_in=1101 captured → units slot an=1110, seg=0110000; tens slot an=1101, seg=1111001.
- Unchanged and restart:
  - Re-capture 1101 with the flag expired → dp stays 1.
  - Capture 1110, then 1111 five cycles later → dp low for 10 cycles counted from the second capture.
- Full sweep: hold bin_valid=1 and step bin_in through the Gray-decoded sequence 0..15 → bin_held tracks each value on every edge; all 16 display encodings appear in the correct slots.
- Mid-operation reset: assert reset_n=0 during a tens slot with the flag active → all outputs go off immediately and bin_held=0. After release, scanning resumes from DIG_U with dp=1.
